// File: rtl/pulseox_seq_ctrl.sv
// Pulse-ox sample buffer mode sequencer: idle -> diagnostic (bounded retries/timeout) -> streaming.
// Optional streaming watchdog is enabled by defining PULSEOX_WDOG_EN.
module pulseox_seq_ctrl #(
  parameter int DIAG_WAIT_CYC = 16,
  parameter int DIAG_RETRIES  = 2,
  parameter int WDOG_CYC      = 1000000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic             in_stop,
  input  logic [1:0]       in_diag_er,
  input  logic             in_afe_rdy,
  input  logic             in_new_samples,
  output logic [1:0]       out_data_control,
  output logic             out_strm_dn,
  output logic             out_busy,
  output logic             out_fault,
  output logic [1:0]       out_fault_code,
  output logic [CNT_W-1:0] out_frame_cnt,
  output logic [7:0]       out_overrun_cnt
);

  localparam int WAIT_W = (DIAG_WAIT_CYC > 2) ? $clog2(DIAG_WAIT_CYC) : 1;
  localparam int ATT_W  = $clog2(DIAG_RETRIES + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DIAG_WAIT_CYC - 1);
  localparam logic [ATT_W-1:0]  RETRY_MAX = ATT_W'(DIAG_RETRIES);

  typedef enum logic [2:0] {IDLE, DIAG, DIAG_CLR, STREAM, FAULT} state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ATT_W-1:0]  attempt;
  logic              frame_pending;
  logic [1:0]        entry_code;
  logic              wdog_trip;

  logic [1:0] ctl_next;
  logic       busy_next, fault_next;
  logic [1:0] code_next;
  logic       stream_active, fwd, frame_inc, ovr_inc, pending_next, start_clear;

  logic diag_pass, diag_fail;
  assign diag_pass = (in_diag_er == 2'b10);
  assign diag_fail = in_diag_er[0];

`ifdef PULSEOX_WDOG_EN
  localparam int WDOG_W = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // A frame completing in the same cycle restarts the watchdog rather than tripping it.
  assign wdog_trip = (state == STREAM) && (wdog_cnt == WDOG_LAST) && !in_new_samples;

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset)
      wdog_cnt <= '0;
    else if (state == STREAM && next_state == STREAM && !in_new_samples)
      wdog_cnt <= wdog_cnt + 1'b1;
    else
      wdog_cnt <= '0;
  end
`else
  assign wdog_trip = 1'b0;
`endif

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    entry_code = 2'b00;
    case (state)
      IDLE: begin
        if (in_start && !in_stop)
          next_state = DIAG;
      end
      DIAG: begin
        if (in_stop) begin
          next_state = IDLE;
        end else if (diag_pass) begin
          next_state = STREAM;
        end else if (diag_fail) begin
          if (attempt < RETRY_MAX) begin
            next_state = DIAG_CLR;
          end else begin
            next_state = FAULT;
            entry_code = 2'b01;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = FAULT;
          entry_code = 2'b10;
        end
      end
      DIAG_CLR: next_state = in_stop ? IDLE : DIAG;
      STREAM: begin
        if (in_stop) begin
          next_state = IDLE;
        end else if (wdog_trip) begin
          next_state = FAULT;
          entry_code = 2'b11;
        end
      end
      FAULT: begin
        if (in_stop)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so every port comes straight from a flop.
  always_comb begin
    ctl_next   = 2'b00;
    busy_next  = 1'b0;
    fault_next = 1'b0;
    code_next  = 2'b00;
    case (next_state)
      DIAG:     begin ctl_next = 2'b01; busy_next = 1'b1; end
      DIAG_CLR: busy_next = 1'b1;
      STREAM:   begin ctl_next = 2'b10; busy_next = 1'b1; end
      FAULT: begin
        fault_next = 1'b1;
        code_next  = (state == FAULT) ? out_fault_code : entry_code;
      end
      default: ;
    endcase

    stream_active = (state == STREAM) && (next_state == STREAM);
    fwd           = stream_active && in_afe_rdy && (!frame_pending || in_new_samples);
    frame_inc     = stream_active && in_new_samples;
    ovr_inc       = stream_active && in_afe_rdy && frame_pending && !in_new_samples;
    if (!stream_active)
      pending_next = 1'b0;
    else if (fwd)
      pending_next = 1'b1;
    else if (in_new_samples)
      pending_next = 1'b0;
    else
      pending_next = frame_pending;
    start_clear = (state == IDLE) && (next_state == DIAG);
  end

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      out_data_control <= 2'b00;
      out_busy         <= 1'b0;
      out_fault        <= 1'b0;
      out_fault_code   <= 2'b00;
      out_strm_dn      <= 1'b0;
      frame_pending    <= 1'b0;
      out_frame_cnt    <= '0;
      out_overrun_cnt  <= 8'd0;
      wait_cnt         <= '0;
      attempt          <= '0;
    end else begin
      out_data_control <= ctl_next;
      out_busy         <= busy_next;
      out_fault        <= fault_next;
      out_fault_code   <= code_next;
      out_strm_dn      <= fwd;
      frame_pending    <= pending_next;

      if (start_clear)
        out_frame_cnt <= '0;
      else if (frame_inc)
        out_frame_cnt <= out_frame_cnt + 1'b1;

      if (start_clear)
        out_overrun_cnt <= 8'd0;
      else if (ovr_inc && out_overrun_cnt != 8'hFF)
        out_overrun_cnt <= out_overrun_cnt + 8'd1;

      if (state == DIAG && next_state == DIAG)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      if (start_clear)
        attempt <= '0;
      else if (state == DIAG && next_state == DIAG_CLR)
        attempt <= attempt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pulseox_seq_ctrl.sv
// Self-checking bench for pulseox_seq_ctrl (default build, watchdog disabled).
module tb_pulseox_seq_ctrl;

  localparam int CNT_W = 16;
  localparam int DIAG_WAIT_CYC = 16;

  logic             clk = 1'b0;
  logic             in_reset = 1'b1;
  logic             in_start = 1'b0;
  logic             in_stop = 1'b0;
  logic [1:0]       in_diag_er = 2'b00;
  logic             in_afe_rdy = 1'b0;
  logic             in_new_samples = 1'b0;
  logic [1:0]       out_data_control;
  logic             out_strm_dn;
  logic             out_busy;
  logic             out_fault;
  logic [1:0]       out_fault_code;
  logic [CNT_W-1:0] out_frame_cnt;
  logic [7:0]       out_overrun_cnt;

  int total = 0;
  int bad = 0;

  // Scoreboard of expected out_strm_dn values and a reference model of the stream gate.
  logic exp_q[$];
  logic m_pending;
  int   m_frames;
  int   m_ovr;

  pulseox_seq_ctrl #(
    .DIAG_WAIT_CYC(DIAG_WAIT_CYC),
    .DIAG_RETRIES(2),
    .WDOG_CYC(1000000),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .in_reset(in_reset),
    .in_start(in_start),
    .in_stop(in_stop),
    .in_diag_er(in_diag_er),
    .in_afe_rdy(in_afe_rdy),
    .in_new_samples(in_new_samples),
    .out_data_control(out_data_control),
    .out_strm_dn(out_strm_dn),
    .out_busy(out_busy),
    .out_fault(out_fault),
    .out_fault_code(out_fault_code),
    .out_frame_cnt(out_frame_cnt),
    .out_overrun_cnt(out_overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_stream();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    in_diag_er = 2'b10;
    tick();
    in_diag_er = 2'b00;
  endtask

  task automatic test_reset();
    tick();
    total++;
    if (out_data_control !== 2'b00 || out_busy !== 1'b0 || out_strm_dn !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctl: got ctl=%b busy=%b dn=%b want 00 0 0", out_data_control, out_busy, out_strm_dn);
    end
    total++;
    if (out_fault !== 1'b0 || out_fault_code !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_fault: got fault=%b code=%b want 0 00", out_fault, out_fault_code);
    end
    total++;
    if (out_frame_cnt !== '0 || out_overrun_cnt !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_cnt: got frames=%0d ovr=%0d want 0 0", out_frame_cnt, out_overrun_cnt);
    end
    in_reset = 1'b0;
    tick();
  endtask

  task automatic test_start_stop_idle();
    in_start = 1'b1;
    in_stop = 1'b1;
    tick();
    in_start = 1'b0;
    in_stop = 1'b0;
    total++;
    if (out_data_control !== 2'b00 || out_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_stop_idle: got ctl=%b busy=%b want 00 0", out_data_control, out_busy);
    end
  endtask

  task automatic test_diag_pass();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    total++;
    if (out_data_control !== 2'b01 || out_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL diag_enter: got ctl=%b busy=%b want 01 1", out_data_control, out_busy);
    end
    tick();
    tick();
    total++;
    if (out_data_control !== 2'b01) begin
      bad++;
      $display("[TB] FAIL diag_wait: got ctl=%b want 01", out_data_control);
    end
    in_diag_er = 2'b10;
    tick();
    in_diag_er = 2'b00;
    total++;
    if (out_data_control !== 2'b10 || out_busy !== 1'b1 || out_fault !== 1'b0) begin
      bad++;
      $display("[TB] FAIL diag_pass: got ctl=%b busy=%b fault=%b want 10 1 0", out_data_control, out_busy, out_fault);
    end
    in_stop = 1'b1;
    tick();
    in_stop = 1'b0;
    total++;
    if (out_data_control !== 2'b00 || out_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stop_stream: got ctl=%b busy=%b want 00 0", out_data_control, out_busy);
    end
  endtask

  task automatic test_diag_retry();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    for (int a = 0; a < 2; a++) begin
      in_diag_er = (a == 0) ? 2'b01 : 2'b11;
      tick();
      in_diag_er = 2'b00;
      total++;
      if (out_data_control !== 2'b00 || out_busy !== 1'b1 || out_fault !== 1'b0) begin
        bad++;
        $display("[TB] FAIL retry_gap%0d: got ctl=%b busy=%b fault=%b want 00 1 0", a, out_data_control, out_busy, out_fault);
      end
      tick();
      total++;
      if (out_data_control !== 2'b01) begin
        bad++;
        $display("[TB] FAIL retry_rediag%0d: got ctl=%b want 01", a, out_data_control);
      end
    end
    in_diag_er = 2'b01;
    tick();
    in_diag_er = 2'b00;
    total++;
    if (out_fault !== 1'b1 || out_fault_code !== 2'b01 || out_data_control !== 2'b00 || out_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL retry_fault: got fault=%b code=%b ctl=%b busy=%b want 1 01 00 0", out_fault, out_fault_code, out_data_control, out_busy);
    end
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    tick();
    total++;
    if (out_fault !== 1'b1 || out_fault_code !== 2'b01 || out_data_control !== 2'b00) begin
      bad++;
      $display("[TB] FAIL fault_sticky: got fault=%b code=%b ctl=%b want 1 01 00", out_fault, out_fault_code, out_data_control);
    end
    in_stop = 1'b1;
    tick();
    in_stop = 1'b0;
    total++;
    if (out_fault !== 1'b0 || out_fault_code !== 2'b00 || out_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fault_clear: got fault=%b code=%b busy=%b want 0 00 0", out_fault, out_fault_code, out_busy);
    end
  endtask

  task automatic test_diag_timeout();
    int early;
    early = 0;
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    for (int i = 1; i < DIAG_WAIT_CYC; i++) begin
      tick();
      if (out_fault !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("[TB] FAIL timeout_early: got %0d early fault cycles want 0", early);
    end
    tick();
    total++;
    if (out_fault !== 1'b1 || out_fault_code !== 2'b10) begin
      bad++;
      $display("[TB] FAIL timeout_fault: got fault=%b code=%b want 1 10", out_fault, out_fault_code);
    end
    in_stop = 1'b1;
    tick();
    in_stop = 1'b0;
  endtask

  task automatic test_stream();
    logic [1:0] pat[$];
    logic exp;
    logic rdy, ns, f;
    enter_stream();
    m_pending = 1'b0;
    m_frames = 0;
    m_ovr = 0;
    for (int k = 0; k < 5; k++) begin
      pat.push_back(2'b10);
      pat.push_back(2'b01);
    end
    pat.push_back(2'b10); pat.push_back(2'b10); pat.push_back(2'b10); pat.push_back(2'b01);
    pat.push_back(2'b10); pat.push_back(2'b11); pat.push_back(2'b01);
    for (int i = 0; i < pat.size(); i++) begin
      rdy = pat[i][1];
      ns = pat[i][0];
      in_afe_rdy = rdy;
      in_new_samples = ns;
      f = rdy && (!m_pending || ns);
      exp_q.push_back(f);
      if (rdy && m_pending && !ns && m_ovr < 255) m_ovr++;
      if (ns) m_frames++;
      m_pending = f ? 1'b1 : (ns ? 1'b0 : m_pending);
      tick();
      exp = exp_q.pop_front();
      total++;
      if (out_strm_dn !== exp) begin
        bad++;
        $display("[TB] FAIL stream_dn[%0d]: got %b want %b", i, out_strm_dn, exp);
      end
      if (i == 9) begin
        total++;
        if (out_frame_cnt !== 16'd5 || out_overrun_cnt !== 8'd0) begin
          bad++;
          $display("[TB] FAIL stream_five: got frames=%0d ovr=%0d want 5 0", out_frame_cnt, out_overrun_cnt);
        end
      end
      if (i == 13) begin
        total++;
        if (out_overrun_cnt !== 8'd2 || out_frame_cnt !== 16'd6) begin
          bad++;
          $display("[TB] FAIL stream_overrun: got ovr=%0d frames=%0d want 2 6", out_overrun_cnt, out_frame_cnt);
        end
      end
    end
    in_afe_rdy = 1'b0;
    in_new_samples = 1'b0;
    tick();
    total++;
    if (out_strm_dn !== 1'b0 || out_frame_cnt !== 16'(m_frames) || out_overrun_cnt !== 8'(m_ovr)) begin
      bad++;
      $display("[TB] FAIL stream_end: got dn=%b frames=%0d ovr=%0d want 0 %0d %0d", out_strm_dn, out_frame_cnt, out_overrun_cnt, m_frames, m_ovr);
    end
  endtask

  task automatic test_overrun_sat();
    logic exp;
    logic f;
    int errs;
    errs = 0;
    in_afe_rdy = 1'b1;
    for (int i = 0; i < 260; i++) begin
      f = !m_pending;
      exp_q.push_back(f);
      if (m_pending && m_ovr < 255) m_ovr++;
      m_pending = 1'b1;
      tick();
      exp = exp_q.pop_front();
      if (out_strm_dn !== exp) errs++;
    end
    in_afe_rdy = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("[TB] FAIL sat_dn: got %0d forwarding errors want 0", errs);
    end
    total++;
    if (out_overrun_cnt !== 8'd255 || m_ovr != 255) begin
      bad++;
      $display("[TB] FAIL sat_ovr: got %0d want 255", out_overrun_cnt);
    end
  endtask

  task automatic test_stop_midframe();
    in_afe_rdy = 1'b1;
    in_stop = 1'b1;
    tick();
    in_afe_rdy = 1'b0;
    in_stop = 1'b0;
    total++;
    if (out_data_control !== 2'b00 || out_busy !== 1'b0 || out_strm_dn !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stop_mid: got ctl=%b busy=%b dn=%b want 00 0 0", out_data_control, out_busy, out_strm_dn);
    end
    total++;
    if (out_frame_cnt !== 16'(m_frames) || out_overrun_cnt !== 8'd255) begin
      bad++;
      $display("[TB] FAIL stop_hold: got frames=%0d ovr=%0d want %0d 255", out_frame_cnt, out_overrun_cnt, m_frames);
    end
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    total++;
    if (out_frame_cnt !== '0 || out_overrun_cnt !== 8'd0 || out_data_control !== 2'b01) begin
      bad++;
      $display("[TB] FAIL restart_clear: got frames=%0d ovr=%0d ctl=%b want 0 0 01", out_frame_cnt, out_overrun_cnt, out_data_control);
    end
    in_diag_er = 2'b10;
    tick();
    in_diag_er = 2'b00;
    in_afe_rdy = 1'b1;
    tick();
    in_afe_rdy = 1'b0;
    total++;
    if (out_strm_dn !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pending_cleared: got dn=%b want 1", out_strm_dn);
    end
    in_stop = 1'b1;
    tick();
    in_stop = 1'b0;
  endtask

  task automatic test_no_wdog();
    enter_stream();
    repeat (1000) tick();
    total++;
    if (out_fault !== 1'b0 || out_data_control !== 2'b10) begin
      bad++;
      $display("[TB] FAIL no_wdog: got fault=%b ctl=%b want 0 10", out_fault, out_data_control);
    end
    in_stop = 1'b1;
    tick();
    in_stop = 1'b0;
  endtask

  task automatic test_reset_midframe();
    enter_stream();
    in_new_samples = 1'b1;
    tick();
    in_new_samples = 1'b0;
    in_afe_rdy = 1'b1;
    tick();
    in_afe_rdy = 1'b0;
    #2;
    in_reset = 1'b1;
    #1;
    total++;
    if (out_strm_dn !== 1'b0 || out_data_control !== 2'b00 || out_busy !== 1'b0 || out_frame_cnt !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got dn=%b ctl=%b busy=%b frames=%0d want 0 00 0 0", out_strm_dn, out_data_control, out_busy, out_frame_cnt);
    end
    @(negedge clk);
    in_reset = 1'b0;
    tick();
    total++;
    if (out_data_control !== 2'b00 || out_strm_dn !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_after: got ctl=%b dn=%b want 00 0", out_data_control, out_strm_dn);
    end
  endtask

  initial begin
    test_reset();
    test_start_stop_idle();
    test_diag_pass();
    test_diag_retry();
    test_diag_timeout();
    test_stream();
    test_overrun_sat();
    test_stop_midframe();
    test_no_wdog();
    test_reset_midframe();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
